// File: rtl/ps2_keypad_pkg.sv
// Shared types and constants for the PS/2 keypad front end: receiver states,
// Set-2 scan codes and GBA KEYINPUT bit positions.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_A      = 8'h22;  // X
  localparam logic [7:0] SC_B      = 8'h1A;  // Z
  localparam logic [7:0] SC_SELECT = 8'h66;  // Backspace
  localparam logic [7:0] SC_START  = 8'h5A;  // Enter
  localparam logic [7:0] SC_RIGHT  = 8'h74;  // extended
  localparam logic [7:0] SC_LEFT   = 8'h6B;  // extended
  localparam logic [7:0] SC_UP     = 8'h75;  // extended
  localparam logic [7:0] SC_DOWN   = 8'h72;  // extended
  localparam logic [7:0] SC_R      = 8'h1B;  // S
  localparam logic [7:0] SC_L      = 8'h1C;  // A

  localparam logic [3:0] KEY_A      = 4'd0;
  localparam logic [3:0] KEY_B      = 4'd1;
  localparam logic [3:0] KEY_SELECT = 4'd2;
  localparam logic [3:0] KEY_START  = 4'd3;
  localparam logic [3:0] KEY_RIGHT  = 4'd4;
  localparam logic [3:0] KEY_LEFT   = 4'd5;
  localparam logic [3:0] KEY_UP     = 4'd6;
  localparam logic [3:0] KEY_DOWN   = 4'd7;
  localparam logic [3:0] KEY_R      = 4'd8;
  localparam logic [3:0] KEY_L      = 4'd9;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = '0;
    if (ext) begin
      case (code)
        SC_RIGHT: r.idx = KEY_RIGHT;
        SC_LEFT:  r.idx = KEY_LEFT;
        SC_UP:    r.idx = KEY_UP;
        SC_DOWN:  r.idx = KEY_DOWN;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_A:      r.idx = KEY_A;
        SC_B:      r.idx = KEY_B;
        SC_SELECT: r.idx = KEY_SELECT;
        SC_START:  r.idx = KEY_START;
        SC_R:      r.idx = KEY_R;
        SC_L:      r.idx = KEY_L;
        default:   r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// Pin-side and key-state-side signals of the PS/2 keypad.
interface ps2_keypad_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] keys;
  logic       key_event;
  logic       frame_err;

  modport master (output ps2_clk, ps2_data, input keys, key_event, frame_err);
  modport slave  (input ps2_clk, ps2_data, output keys, key_event, frame_err);
endinterface

// File: rtl/ps2_keypad_rx.sv
// PS/2 frame receiver: pin synchronizer, clock stability filter, 11-bit frame
// FSM with odd-parity/start/stop checks and an inactivity timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       err_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          strobe, dat;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  assign dat = dat_sync_q[1];

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == CW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign strobe = filt_q & ~filt_d;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    // A strobe wins over a timeout expiring in the same cycle.
    if (strobe) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {dat, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat && (^{shift_q, par_q})) valid_d = 1'b1;
          else                            err_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shift_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to GBA KEYINPUT vector: frame receiver plus E0/F0 prefix
// decoder holding press/release state for the ten mapped keys.
module ps2_keypad
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic         clk,
  input logic         rstn,
  ps2_keypad_if.slave bus
);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;
  key_hit_t   hit;

  logic [9:0] keys_q, keys_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       event_q, ferr_q;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (clk),
    .rstn         (rstn),
    .ps2_clk_i    (bus.ps2_clk),
    .ps2_data_i   (bus.ps2_data),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .err_o        (rx_err)
  );

  always_comb begin
    keys_d = keys_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    hit    = key_lookup(rx_byte, ext_q);
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (hit.hit) keys_d[hit.idx] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      keys_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      event_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      keys_q  <= keys_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      event_q <= (keys_d != keys_q);
      ferr_q  <= rx_err;
    end
  end

  assign bus.keys      = keys_q;
  assign bus.key_event = event_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: frames are bit-banged onto the pins, the
// expected key/error events are queued and popped as the DUT pulses.
module tb_ps2_keypad;

  localparam int HALF = 10;

  typedef struct {
    bit         is_err;
    logic [9:0] keys;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #10 clk = ~clk;

  ps2_keypad_if bus ();

  ps2_keypad #(
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (50000)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t       q[$];
  exp_t       e;
  int         ncmp = 0;
  int         nerr = 0;
  logic [9:0] m_keys = '0;
  bit         m_ext  = 1'b0;
  bit         m_brk  = 1'b0;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_err();
    exp_t x;
    x.is_err = 1'b1;
    x.keys   = m_keys;
    q.push_back(x);
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  // Reference decoder: scan code -> KEYINPUT bit, -1 when unmapped.
  task automatic model_byte(input logic [7:0] b);
    int         idx;
    logic [9:0] nk;
    exp_t       x;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      idx = -1;
      if (m_ext) begin
        case (b)
          8'h74: idx = 4;
          8'h6B: idx = 5;
          8'h75: idx = 6;
          8'h72: idx = 7;
          default: idx = -1;
        endcase
      end else begin
        case (b)
          8'h22: idx = 0;
          8'h1A: idx = 1;
          8'h66: idx = 2;
          8'h5A: idx = 3;
          8'h1B: idx = 8;
          8'h1C: idx = 9;
          default: idx = -1;
        endcase
      end
      nk = m_keys;
      if (idx >= 0) nk[idx] = !m_brk;
      if (nk != m_keys) begin
        x.is_err = 1'b0;
        x.keys   = nk;
        q.push_back(x);
      end
      m_keys = nk;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (glitch && c == 3) bus.ps2_clk = 1'b0;
        if (glitch && c == 5) bus.ps2_clk = 1'b1;
      end
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit glitch = 1'b0);
    logic par;
    par = (~^b) ^ bad_par;
    if (bad_par) push_err();
    else         model_byte(b);
    send_bits({1'b1, par, b, 1'b0}, 11, glitch);
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic check_done(input string tag);
    ncmp++;
    assert (q.size() == 0) else begin
      nerr++;
      $error("FAIL %s_pending: observed %0d outstanding events expected 0", tag, q.size());
    end
    chk({tag, "_keys"}, bus.keys, m_keys);
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && (bus.key_event === 1'b1 || bus.frame_err === 1'b1)) begin
      ncmp++;
      assert (!(bus.key_event === 1'b1 && bus.frame_err === 1'b1)) else begin
        nerr++;
        $error("FAIL both_pulses: observed key_event=1 frame_err=1 expected at most one");
      end
      ncmp++;
      assert (q.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_pulse: observed key_event=%b frame_err=%b keys=%h expected none",
               bus.key_event, bus.frame_err, bus.keys);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pulse_kind", {9'd0, bus.frame_err}, {9'd0, e.is_err});
        chk("event_keys", bus.keys, e.keys);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn         = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_keys", bus.keys, 10'h000);
    chk("reset_event", {9'd0, bus.key_event}, 10'h000);
    chk("reset_ferr", {9'd0, bus.frame_err}, 10'h000);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h22);
    check_done("press_a");
    send_frame(8'hF0); send_frame(8'h22);
    check_done("release_a");

    send_frame(8'hE0); send_frame(8'h75);
    send_frame(8'hE0); send_frame(8'h6B);
    check_done("up_left");
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check_done("release_up");
    send_frame(8'h75);
    check_done("plain_75");

    push_err();
    send_bits(11'h001, 1, 1'b0);
    repeat (2 * HALF) @(negedge clk);
    check_done("start_err");

    send_frame(8'h1C, 1'b1);
    check_done("parity_err");
    send_frame(8'h1C);
    check_done("press_l");
    send_frame(8'hF0); send_frame(8'h1C);
    check_done("release_l");
    send_frame(8'hE0); send_frame(8'h11, 1'b1); send_frame(8'h75);
    check_done("err_clears_ext");

    push_err();
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
    repeat (50020) @(negedge clk);
    check_done("timeout");
    send_frame(8'h5A);
    check_done("start_after_tmo");

    send_frame(8'h1B, 1'b0, 1'b1);
    check_done("glitch_r");
    send_frame(8'hAA); send_frame(8'hFA); send_frame(8'hE1);
    check_done("unmapped");

    send_frame(8'hE0); send_frame(8'h74);
    send_frame(8'hE0); send_frame(8'h72);
    send_frame(8'h66);
    check_done("right_down_sel");

    send_frame(8'h22);
    check_done("press_before_rst");
    send_bits({1'b1, 1'b0, 8'h66, 1'b0}, 3, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("async_rst_keys", bus.keys, 10'h000);
    m_keys = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    q.delete();
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_done("after_rst");

    send_frame(8'h1A);
    send_frame(8'h1A);
    send_frame(8'h1A);
    check_done("typematic_b");
    send_frame(8'hF0); send_frame(8'h1A);
    check_done("release_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ps2_keypad.md
# ps2_keypad

PS/2 keyboard front end that turns raw `PS2_CLK`/`PS2_DAT` traffic into a 10-bit GBA key-state vector for the I/O register file (`io_register.key_data`, mirrored on `LED`). It receives and checks Set-2 scan-code frames, tracks the E0/F0 prefixes, and holds press/release state for the ten mapped keys. It runs in the 50 MHz system domain, so downstream logic sees a clean, stable vector.

## Interface
- `FILTER_LEN`, 4: consecutive equal synchronized samples needed to accept a `ps2_clk` level.
- `TIMEOUT_CYC`, 50000: idle cycles inside a frame before abort (1 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `keys`  out  10  pressed state, active-high, GBA KEYINPUT order: [0]A [1]B [2]Select [3]Start [4]Right [5]Left [6]Up [7]Down [8]R [9]L.
- `key_event`  out  1  one-cycle pulse when `keys` changes.
- `frame_err`  out  1  one-cycle pulse on parity, start, stop or timeout error.

## Operation
- **Input conditioning:**
  - Both pins pass through a 2-FF synchronizer.
  - `ps2_clk` then goes through a `FILTER_LEN` stability filter.
  - A falling edge of the filtered clock is the sample strobe; `ps2_data` is sampled from its synchronized copy on that strobe.
- **Frame receiver FSM.** Each strobe advances one state:
  - IDLE: a strobe with data=0 starts a frame and goes to DATA. A strobe with data=1 is a start error: pulse `frame_err`, stay in IDLE.
  - DATA: 8 bits, LSB first, shifted in; a 3-bit counter selects PARITY after bit 7.
  - PARITY: captures the parity bit. Odd parity is required: data bits plus parity contain an odd number of ones.
  - STOP: requires data=1.
    - Valid stop with good parity: the byte goes to the decoder.
    - Any other outcome: pulse `frame_err` and discard the byte.
    - Either way, return to IDLE.
- **Timeout:** in any non-IDLE state, if no strobe arrives for `TIMEOUT_CYC` cycles, return to IDLE, pulse `frame_err` and discard the byte. The counter restarts on every strobe.
- **Decoder**, holding flags `ext` and `brk`:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is looked up with the current `ext`, then both flags clear.
  - Key map:
    - X 0x22 → A; Z 0x1A → B; Backspace 0x66 → Select; Enter 0x5A → Start.
    - E0 74 → Right; E0 6B → Left; E0 75 → Up; E0 72 → Down.
    - S 0x1B → R; A 0x1C → L.
  - A hit sets the bit, or clears it when `brk`=1.
  - Unmapped codes (including 0xAA, 0xFA, 0xE1, and non-extended 0x74 etc.) change nothing but still clear the flags.
  - A discarded or erroneous frame clears `ext` and `brk`.
- **Events and state:**
  - Typematic repeat of a held key leaves `keys` unchanged and gives no `key_event`.
  - Opposite directions may be held together; no arbitration.

## Timing
- Reset (async assert, sync release): `keys`=0, `key_event`=0, `frame_err`=0, FSM IDLE, `ext`=`brk`=0, timeout counter 0. An in-flight frame is discarded.
- Strobe latency: 2 (sync) + `FILTER_LEN` cycles after the pin falls. Glitches shorter than `FILTER_LEN` cycles are ignored.
- `keys`, `key_event` and `frame_err` are registered. They update on the cycle after the strobe that samples the stop bit (or the timeout/error cycle).
- Total latency from the stop-bit pin fall to the `keys` update is 3 + `FILTER_LEN` cycles, fixed.
- `key_event` and `frame_err` never stay high longer than 1 cycle. They cannot both fire for the same frame.
- A strobe arriving on the same cycle as the timeout expiry is honoured; no timeout fires.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum (IDLE/DATA/PARITY/STOP);
  - scan-code constants (`SC_EXT`=8'hE0, `SC_BRK`=8'hF0, the ten key codes);
  - the KEYINPUT bit-index constants.
- Sub-module `ps2_rx`: synchronizer, filter, frame FSM and timeout. It outputs `byte_valid`, `byte`, `err`.
- The top level holds the decoder and the `keys` register.

## Test plan
- **Press/release:** reset, send 0x22 → `keys`=10'h001 with one `key_event`; then F0 22 → `keys`=0 with one `key_event`.
- **Extended keys:** E0 75, then E0 6B → `keys`=10'h060; E0 F0 75 → 10'h020; plain 0x75 (no E0) → unchanged.
- **Parity error:** 0x1C sent with even parity → one `frame_err` and `keys` unchanged. A following good F0 prefix is not corrupted: the next byte is decoded normally.
- **Timeout:** stop clocking after 4 data bits, wait 50000 cycles → `frame_err` pulse and FSM IDLE. A following 0x5A frame gives `keys`[3]=1.
- **Glitch immunity:** 2-cycle low glitches on `ps2_clk` between real edges → no extra bits shifted; 0x1B decodes to `keys`[8]=1.
- **Reset and repeat:** assert `rstn` mid-frame while holding keys → `keys`=0 immediately. After release, a fresh full frame decodes correctly, and typematic 0x1A ×3 gives exactly one `key_event`.
